// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, registers the fetched word into
// IF/ID, and hands it to decode over a valid/ready handshake.
module fetch_unit #(
  parameter int         DATA_LENGTH = 32,
  parameter int         MEM_LENGTH  = 32,
  parameter int         RESET_PC    = 0,
  parameter logic [5:0] HALT_OPCODE = 6'h3F,
  parameter int         CNT_WIDTH   = 16,
  localparam int        AW          = $clog2(MEM_LENGTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic [AW-1:0]          imem_addr,
  input  logic [DATA_LENGTH-1:0] imem_data,
  input  logic                   redirect_valid,
  input  logic [AW-1:0]          redirect_pc,
  output logic                   instr_valid,
  input  logic                   dec_ready,
  output logic [DATA_LENGTH-1:0] instr_o,
  output logic [AW-1:0]          instr_pc,
  output logic                   halted,
  output logic [CNT_WIDTH-1:0]   fetch_count
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t        state;
  logic [AW-1:0] pc;
  logic          accept;
  logic          can_cap;
  logic          is_halt;

  assign imem_addr = pc;
  assign accept    = instr_valid & dec_ready;
  assign can_cap   = ~instr_valid | dec_ready;
  assign is_halt   = imem_data[DATA_LENGTH-1 -: 6] == HALT_OPCODE;

  // PC, IF/ID register and run/halt control
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      pc          <= AW'(RESET_PC);
      instr_valid <= 1'b0;
      instr_o     <= '0;
      instr_pc    <= '0;
      halted      <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (redirect_valid) begin
            pc          <= redirect_pc;
            instr_valid <= 1'b0;
          end else if (can_cap) begin
            instr_o     <= imem_data;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            if (is_halt) begin
              state  <= HALT;
              halted <= 1'b1;
            end else begin
              pc <= pc + AW'(1);
            end
          end
        end
        HALT: begin
          if (redirect_valid) begin
            pc          <= redirect_pc;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
            state       <= RUN;
          end else if (accept) begin
            instr_valid <= 1'b0;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  // count completed handshakes; a redirect voids the handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count <= '0;
    end else if (accept && !redirect_valid) begin
      fetch_count <= fetch_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic,
// checked every cycle against a transaction-level model.
module tb_fetch_unit;

  localparam int DL = 32;
  localparam int ML = 32;
  localparam int AW = 5;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] imem_addr;
  logic [DL-1:0] imem_data;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          instr_valid;
  logic          dec_ready;
  logic [DL-1:0] instr_o;
  logic [AW-1:0] instr_pc;
  logic          halted;
  logic [CW-1:0] fetch_count;

  logic [DL-1:0] mem [ML];

  int checks = 0;
  int errors = 0;

  // model state
  int          m_pc;
  bit          m_valid;
  logic [31:0] m_instr;
  int          m_ipc;
  bit          m_halt;
  int          m_cnt;

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr];

  fetch_unit #(
    .DATA_LENGTH(DL),
    .MEM_LENGTH (ML),
    .RESET_PC   (0),
    .HALT_OPCODE(6'h3F),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .instr_valid   (instr_valid),
    .dec_ready     (dec_ready),
    .instr_o       (instr_o),
    .instr_pc      (instr_pc),
    .halted        (halted),
    .fetch_count   (fetch_count)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] rand_word(input bit allow_halt);
    logic [31:0] w;
    w = $urandom;
    if (w[31:26] == 6'h3F) w[31] = 1'b0;
    if (allow_halt && $urandom_range(0, 9) == 0) w[31:26] = 6'h3F;
    return w;
  endfunction

  // reference model advances on each edge, then outputs are compared
  always @(posedge clk) begin
    bit acc;
    bit rd;
    int rpc;
    acc = m_valid && dec_ready;
    rd  = redirect_valid;
    rpc = int'(redirect_pc);
    if (!rst_n) begin
      m_pc = 0; m_valid = 0; m_instr = 0; m_ipc = 0; m_halt = 0; m_cnt = 0;
    end else begin
      if (acc && !rd) m_cnt = (m_cnt + 1) % 65536;
      if (rd) begin
        m_pc = rpc;
        m_valid = 0;
        m_halt = 0;
      end else if (m_halt) begin
        if (acc) m_valid = 0;
      end else if (!m_valid || dec_ready) begin
        m_instr = mem[m_pc];
        m_ipc = m_pc;
        m_valid = 1;
        if (m_instr[31:26] == 6'h3F) m_halt = 1;
        else m_pc = (m_pc + 1) % ML;
      end
    end
    #1;
    chk("addr", 64'(imem_addr), 64'(m_pc));
    chk("valid", 64'(instr_valid), 64'(m_valid));
    chk("halted", 64'(halted), 64'(m_halt));
    chk("count", 64'(fetch_count), 64'(m_cnt));
    if (m_valid) begin
      chk("instr", 64'(instr_o), 64'(m_instr));
      chk("ipc", 64'(instr_pc), 64'(m_ipc));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [31:0] w;
    rst_n = 1'b0;
    dec_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    for (int i = 0; i < ML; i++) mem[i] = rand_word(1'b0);

    // reset values
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(instr_valid), 64'd0);
    chk("rst_addr", 64'(imem_addr), 64'd0);
    chk("rst_count", 64'(fetch_count), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_instr", 64'(instr_o), 64'd0);
    rst_n = 1'b1;
    dec_ready = 1'b1;

    // back-to-back stream A,B,C,D
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("b2b_instr", 64'(instr_o), 64'(mem[i]));
      chk("b2b_ipc", 64'(instr_pc), 64'(i));
    end
    chk("b2b_cnt3", 64'(fetch_count), 64'd3);
    tick();
    chk("b2b_cnt4", 64'(fetch_count), 64'd4);

    // stall for 3 clocks while mem[4] is presented
    dec_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_instr", 64'(instr_o), 64'(mem[4]));
      chk("stall_ipc", 64'(instr_pc), 64'd4);
      chk("stall_addr", 64'(imem_addr), 64'd5);
    end
    dec_ready = 1'b1;
    tick();
    chk("rel_instr", 64'(instr_o), 64'(mem[5]));
    chk("rel_cnt", 64'(fetch_count), 64'd5);

    // redirect with simultaneous ready: handshake voided
    redirect_valid = 1'b1;
    redirect_pc = 5'd20;
    tick();
    redirect_valid = 1'b0;
    chk("rdr_valid", 64'(instr_valid), 64'd0);
    chk("rdr_cnt", 64'(fetch_count), 64'd5);
    chk("rdr_addr", 64'(imem_addr), 64'd20);
    tick();
    chk("rdr_instr", 64'(instr_o), 64'(mem[20]));
    chk("rdr_ipc", 64'(instr_pc), 64'd20);

    // HALT word at address 5
    w = mem[5];
    w[31:26] = 6'h3F;
    mem[5] = w;
    redirect_valid = 1'b1;
    redirect_pc = 5'd3;
    tick();
    redirect_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("halt_instr", 64'(instr_o), 64'(w));
    chk("halt_flag", 64'(halted), 64'd1);
    chk("halt_cnt", 64'(fetch_count), 64'd7);
    tick();
    chk("halt_drop", 64'(instr_valid), 64'd0);
    chk("halt_cnt2", 64'(fetch_count), 64'd8);
    tick();
    chk("halt_addr", 64'(imem_addr), 64'd5);
    chk("halt_stay", 64'(instr_valid), 64'd0);
    redirect_valid = 1'b1;
    redirect_pc = 5'd0;
    tick();
    redirect_valid = 1'b0;
    chk("unhalt", 64'(halted), 64'd0);
    tick();
    chk("resume_ipc", 64'(instr_pc), 64'd0);
    chk("resume_instr", 64'(instr_o), 64'(mem[0]));

    // PC wrap 31 -> 0
    redirect_valid = 1'b1;
    redirect_pc = 5'd30;
    tick();
    redirect_valid = 1'b0;
    tick();
    tick();
    chk("wrap_31", 64'(instr_pc), 64'd31);
    tick();
    chk("wrap_0", 64'(instr_pc), 64'd0);
    tick();

    // asynchronous reset mid-stream
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(instr_valid), 64'd0);
    chk("arst_instr", 64'(instr_o), 64'd0);
    chk("arst_addr", 64'(imem_addr), 64'd0);
    chk("arst_count", 64'(fetch_count), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("refetch_ipc", 64'(instr_pc), 64'd0);
    chk("refetch_instr", 64'(instr_o), 64'(mem[0]));

    // random traffic, including HALT words and redirects
    for (int i = 0; i < ML; i++) mem[i] = rand_word(1'b1);
    for (int c = 0; c < 3000; c++) begin
      dec_ready = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 99) < 8);
      redirect_pc = AW'($urandom_range(0, ML - 1));
      if (c == 1500) begin
        rst_n = 1'b0;
        #1;
        chk("rnd_arst", 64'(instr_valid), 64'd0);
      end else if (c == 1502) begin
        rst_n = 1'b1;
      end
      if ($urandom_range(0, 49) == 0) begin
        for (int i = 0; i < ML; i++) mem[i] = rand_word(1'b1);
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
